// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the execute stage and the mult/div unit
//
// master: pipeline side (drives start/op/a/b/cancel, observes status and HI/LO write port)
// slave : mult_div_unit side
//   start     request, accepted only while ready
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      rs / rt operands
//   cancel    abort the in-flight operation
//   ready     unit idle
//   busy      unit working (inverse of ready)
//   hi_data   high product / remainder
//   lo_data   low product / quotient
//   hi_write  one-cycle write pulse to HI
//   lo_write  one-cycle write pulse to LO (always equal to hi_write)

interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        ready;
    logic        busy;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
    logic        hi_write;
    logic        lo_write;

    modport master (
        output start, op, a, b, cancel,
        input  ready, busy, hi_data, lo_data, hi_write, lo_write
    );

    modport slave (
        input  start, op, a, b, cancel,
        output ready, busy, hi_data, lo_data, hi_write, lo_write
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MIPS MULT/MULTU/DIV/DIVU unit driving the HI/LO write ports
//
// Parameters:
//   MUL_LATENCY  cycles spent in the MUL state (1..4)
// Ports:
//   clk     rising-edge clock
//   resetn  synchronous active-low reset
//   bus     mult_div_unit_if.slave (request, status and HI/LO write port)

module mult_div_unit #(
    parameter int MUL_LATENCY = 1
) (
    input  logic            clk,
    input  logic            resetn,
    mult_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0] MUL_LAST = 5'(MUL_LATENCY - 1);
    localparam logic [4:0] DIV_LAST = 5'd31;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;

    // For a multiply these hold the raw operands; for a divide a_q is the
    // dividend magnitude that shifts out MSB-first while quotient bits shift in,
    // and b_q is the divisor magnitude.
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] rem_q;
    logic        mul_unsigned;
    logic        neg_quo;
    logic        neg_rem;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        accept;
    logic        signed_div;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        mul_fin;
    logic        div_fin;

    // Multiply datapath: sign- or zero-extend to 64 bits; the low 64 bits of the
    // product of extended values are the exact signed/unsigned result.
    logic [63:0] mul_ext_a;
    logic [63:0] mul_ext_b;
    logic [63:0] mul_prod;

    // Restoring divide step
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] div_rem_nx;
    logic [31:0] div_quo_nx;

    assign accept     = (state == IDLE) && bus.start && !bus.cancel;
    assign signed_div = (bus.op == 2'b10);
    assign abs_a      = (signed_div && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    assign abs_b      = (signed_div && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

    assign mul_ext_a  = {{32{a_q[31] & ~mul_unsigned}}, a_q};
    assign mul_ext_b  = {{32{b_q[31] & ~mul_unsigned}}, b_q};
    assign mul_prod   = mul_ext_a * mul_ext_b;

    assign div_shift  = {rem_q, a_q[31]};
    assign div_diff   = div_shift - {1'b0, b_q};
    assign div_ge     = (div_shift >= {1'b0, b_q});
    assign div_rem_nx = div_ge ? div_diff[31:0] : div_shift[31:0];
    assign div_quo_nx = {a_q[30:0], div_ge};

    assign mul_fin    = (state == MUL) && !bus.cancel && (cnt == MUL_LAST);
    assign div_fin    = (state == DIV) && !bus.cancel && (cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_next;
            if ((state == MUL || state == DIV) && state_next == state)
                cnt <= cnt + 5'd1;
            else
                cnt <= 5'd0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = bus.op[1] ? DIV : MUL;
            MUL: begin
                if (bus.cancel)           state_next = IDLE;
                else if (cnt == MUL_LAST) state_next = DONE;
            end
            DIV: begin
                if (bus.cancel)           state_next = IDLE;
                else if (cnt == DIV_LAST) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            rem_q        <= 32'd0;
            mul_unsigned <= 1'b0;
            neg_quo      <= 1'b0;
            neg_rem      <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else begin
            if (accept) begin
                rem_q        <= 32'd0;
                mul_unsigned <= bus.op[0];
                if (bus.op[1]) begin
                    a_q <= abs_a;
                    b_q <= abs_b;
                end else begin
                    a_q <= bus.a;
                    b_q <= bus.b;
                end
                // A zero divisor must leave the all-ones quotient untouched; the
                // remainder then equals |a| and the sign fixup restores the original a.
                neg_quo <= signed_div && (bus.a[31] ^ bus.b[31]) && (bus.b != 32'd0);
                neg_rem <= signed_div && bus.a[31];
            end else if (state == DIV) begin
                a_q   <= div_quo_nx;
                rem_q <= div_rem_nx;
            end

            if (mul_fin) begin
                hi_q <= mul_prod[63:32];
                lo_q <= mul_prod[31:0];
            end else if (div_fin) begin
                hi_q <= neg_rem ? (32'd0 - div_rem_nx) : div_rem_nx;
                lo_q <= neg_quo ? (32'd0 - div_quo_nx) : div_quo_nx;
            end
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.hi_write = (state == DONE);
    assign bus.lo_write = (state == DONE);
    assign bus.hi_data  = hi_q;
    assign bus.lo_data  = lo_q;

endmodule
